// File: rtl/serial_loader_8bit.sv
// Serial-to-parallel loader: assembles a qualified serial bit stream into
// WIDTH-bit words, framed by sync, and hands each completed word to a
// downstream register stage through a valid/ready hold buffer.
//
// state | meaning
// IDLE  | waiting for the first sync after clear; serial data ignored
// SHIFT | framing; bits accumulate, words complete back-to-back

module serial_loader_8bit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit REQ_SYNC  = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             si,
  input  logic             si_en,
  input  logic             sync,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic [3:0]       bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] base_sr;
  logic [WIDTH-1:0] shifted;
  logic             take;
  logic             complete;

  // State register; clear picks the start state from REQ_SYNC.
  always_ff @(posedge clk) begin
    if (clear) state_q <= REQ_SYNC ? IDLE : SHIFT;
    else       state_q <= state_d;
  end

  // Next state: the first sync opens framing, which then never closes.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && sync) state_d = SHIFT;
  end

  // Datapath/output next values: shifting, completion and handshake.
  always_comb begin
    // sync discards any partial word, so the shift starts from an empty register
    base_sr  = sync ? '0 : sr_q;
    shifted  = MSB_FIRST ? {base_sr[WIDTH-2:0], si} : {si, base_sr[WIDTH-1:1]};
    // a sync bit is always bit 0, so it can never complete a word
    take     = si_en && (state_q == SHIFT || sync);
    complete = take && !sync && (cnt_q == LAST_CNT);

    sr_d    = base_sr;
    cnt_d   = sync ? 4'd0 : cnt_q;
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (take) begin
      sr_d  = shifted;
      cnt_d = complete ? 4'd0 : cnt_d + 4'd1;
    end

    if (complete) begin
      q_d     = shifted;
      valid_d = 1'b1;
      if (valid_q && !out_ready) ovr_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      sr_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 4'd0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Q         = q_q;
  assign out_valid = valid_q;
  assign bit_cnt   = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_loader_8bit.sv
// Bench for serial_loader_8bit: two instances (MSB-first with sync required,
// LSB-first free-running) share stimulus and are checked every cycle against
// a frame-level reference model, plus table rows and directed corner cases.

module tb_serial_loader_8bit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clear, si, si_en, sync, out_ready;
  logic [W-1:0] q_m, q_l;
  logic v_m, v_l, o_m, o_l;
  logic [3:0] c_m, c_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_loader_8bit #(.WIDTH(W), .MSB_FIRST(1'b1), .REQ_SYNC(1'b1)) dut_m (
    .clk(clk), .clear(clear), .si(si), .si_en(si_en), .sync(sync),
    .out_ready(out_ready), .Q(q_m), .out_valid(v_m), .bit_cnt(c_m), .overrun(o_m)
  );

  serial_loader_8bit #(.WIDTH(W), .MSB_FIRST(1'b0), .REQ_SYNC(1'b0)) dut_l (
    .clk(clk), .clear(clear), .si(si), .si_en(si_en), .sync(sync),
    .out_ready(out_ready), .Q(q_l), .out_valid(v_l), .bit_cnt(c_l), .overrun(o_l)
  );

  // Reference model: index 0 = dut_m, index 1 = dut_l.
  bit framing [2];
  bit bq      [2][$];
  int mq      [2];
  bit mv      [2];
  bit mo      [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit msb, rs, done, xfer;
    int word;
    msb = (k == 0);
    rs  = (k == 0);
    if (clear) begin
      bq[k].delete();
      mq[k] = 0; mv[k] = 0; mo[k] = 0;
      framing[k] = !rs;
      return;
    end
    xfer = mv[k] && out_ready;
    done = 0;
    word = 0;
    if (sync) begin
      framing[k] = 1;
      bq[k].delete();
    end
    if (framing[k] && si_en) begin
      bq[k].push_back(si);
      if (bq[k].size() == W) begin
        for (int i = 0; i < W; i++)
          if (bq[k][i]) word |= msb ? (1 << (W - 1 - i)) : (1 << i);
        bq[k].delete();
        done = 1;
      end
    end
    if (done) begin
      if (mv[k] && !out_ready) mo[k] = 1;
      mq[k] = word;
      mv[k] = 1;
    end else if (xfer) begin
      mv[k] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("m_q",   int'(q_m), mq[0]);
    chk("m_vld", int'(v_m), int'(mv[0]));
    chk("m_cnt", int'(c_m), bq[0].size());
    chk("m_ovr", int'(o_m), int'(mo[0]));
    chk("l_q",   int'(q_l), mq[1]);
    chk("l_vld", int'(v_l), int'(mv[1]));
    chk("l_cnt", int'(c_l), bq[1].size());
    chk("l_ovr", int'(o_l), int'(mo[1]));
  endtask

  task automatic idle_in();
    clear = 0; si = 0; si_en = 0; sync = 0;
  endtask

  task automatic do_clear();
    idle_in();
    clear = 1;
    cycle();
    clear = 0;
  endtask

  // Sends w in the given bit order; optional sync on the first bit and gaps between bits.
  task automatic send_word(input logic [7:0] w, input bit msb, input bit with_sync, input int gap);
    logic [7:0] v;
    v = w;
    for (int i = 0; i < W; i++) begin
      si    = msb ? v[W-1-i] : v[i];
      si_en = 1;
      sync  = with_sync && (i == 0);
      cycle();
      si_en = 0; sync = 0;
      for (int g = 0; g < gap; g++) cycle();
    end
  endtask

  typedef struct {
    logic clr, s, en, sy, rdy;
    logic [7:0] eq;
    logic ev;
    logic [3:0] ec;
    logic eo;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] pat;
    pat = 8'hA5;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[i+1] = '{1'b0, pat[7-i], 1'b1, (i == 0), 1'b1,
                   (i == 7) ? 8'hA5 : 8'h00, (i == 7), 4'((i + 1) % 8), 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0, 1'b0};

    idle_in();
    out_ready = 1;

    // 1: REQ_SYNC instance ignores data without sync
    do_clear();
    si = 1; si_en = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t1_cnt", int'(c_m), 0);
      chk("t1_vld", int'(v_m), 0);
      chk("t1_q",   int'(q_m), 0);
    end
    idle_in();

    // 2: table-driven 0xA5 MSB-first, consumed immediately
    for (int r = 0; r < 10; r++) begin
      clear = tbl[r].clr; si = tbl[r].s; si_en = tbl[r].en;
      sync = tbl[r].sy; out_ready = tbl[r].rdy;
      cycle();
      chk("tbl_q",   int'(q_m), int'(tbl[r].eq));
      chk("tbl_vld", int'(v_m), int'(tbl[r].ev));
      chk("tbl_cnt", int'(c_m), int'(tbl[r].ec));
      chk("tbl_ovr", int'(o_m), int'(tbl[r].eo));
    end
    idle_in();

    // 3: LSB-first with 2-cycle gaps
    do_clear();
    send_word(8'hF0, 1'b0, 1'b1, 2);
    chk("t3_q_l", int'(q_l), 8'hF0);
    chk("t3_q_m", int'(q_m), 8'h0F);

    // 4: partial word discarded by sync
    do_clear();
    sync = 1; si_en = 1; si = 1; cycle();
    sync = 0;
    for (int i = 0; i < 4; i++) begin si = i[0]; cycle(); end
    chk("t4_cnt_pre", int'(c_m), 5);
    idle_in();
    send_word(8'h5A, 1'b1, 1'b1, 0);
    chk("t4_q", int'(q_m), 8'h5A);
    chk("t4_vld", int'(v_m), 1);

    // 5: overrun with out_ready low
    do_clear();
    out_ready = 0;
    send_word(8'h11, 1'b1, 1'b1, 0);
    chk("t5_ovr_first", int'(o_m), 0);
    send_word(8'h22, 1'b1, 1'b0, 0);
    chk("t5_vld", int'(v_m), 1);
    chk("t5_q",   int'(q_m), 8'h22);
    chk("t5_ovr", int'(o_m), 1);
    out_ready = 1; cycle(); out_ready = 0;
    chk("t5_vld_after", int'(v_m), 0);
    chk("t5_q_after",   int'(q_m), 8'h22);
    chk("t5_ovr_after", int'(o_m), 1);
    cycle(); cycle();
    chk("t5_ovr_sticky", int'(o_m), 1);

    // 6: clear beats sync/si_en mid-frame
    out_ready = 1;
    sync = 1; si_en = 1; si = 1; cycle();
    sync = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_cnt_pre", int'(c_m), 4);
    clear = 1; sync = 1; si_en = 1; cycle();
    idle_in();
    chk("t6_q",   int'(q_m), 0);
    chk("t6_vld", int'(v_m), 0);
    chk("t6_cnt", int'(c_m), 0);
    chk("t6_ovr", int'(o_m), 0);
    si_en = 1; si = 1; cycle(); idle_in();
    chk("t6_idle", int'(c_m), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      clear     = ($urandom_range(0, 199) == 0);
      sync      = ($urandom_range(0, 19) == 0);
      si_en     = $urandom_range(0, 1);
      si        = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_loader_8bit.md
Name: serial_loader_8bit

Overview:
- Upstream feeder for the 8-bit register stage. It assembles a serial bit stream into parallel words.
- Each completed word is presented on Q with a valid/ready hold buffer, so the register stage can load it.
- Sync input for frame alignment; sticky overrun flag when a word is lost.

Parameters:
WIDTH, 8, bits per word (supported 2..15).
MSB_FIRST, 1, 1 = first received bit lands in Q[WIDTH-1]; 0 = first bit lands in Q[0].
REQ_SYNC, 1, 1 = ignore serial data after clear until the first sync; 0 = start framing immediately after clear.

Ports:
clk  input  1  system clock, all state on rising edge
clear  input  1  reset, synchronous, active-high
si  input  1  serial data bit
si_en  input  1  qualifies si; bit sampled only when si_en=1
sync  input  1  frame start marker; restarts the bit count
out_ready  input  1  consumer accepts Q this cycle (tie high for a free-running register)
Q  output  WIDTH  last completed word
out_valid  output  1  Q holds an unconsumed word
bit_cnt  output  4  bits collected in the current partial word, 0..WIDTH-1
overrun  output  1  sticky: a completed word overwrote an unconsumed one

Behaviour:
- Clock and reset: one clock `clk`; reset `clear` is synchronous and active-high.
- On clear=1 at an edge:
  - Shift register, Q, out_valid, bit_cnt and overrun all go to 0.
  - State goes to IDLE if REQ_SYNC=1, else SHIFT.
  - clear overrides all other inputs in that cycle.
- States: IDLE, SHIFT.
- IDLE:
  - si_en alone is ignored; bit_cnt stays 0.
  - sync=1 moves the state to SHIFT.
  - If si_en=1 in the same cycle as sync, that bit is captured as bit 0 of the frame and bit_cnt becomes 1.
- SHIFT, per edge with si_en=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], si}.
  - MSB_FIRST=0: sr <= {si, sr[WIDTH-1:1]}.
  - bit_cnt increments.
- si_en=0 cycles (gaps): no change to sr or bit_cnt.
- Word completion (si_en=1 while bit_cnt = WIDTH-1):
  - Q is loaded with the assembled word including this bit, on the same edge.
  - bit_cnt goes to 0 and out_valid goes to 1.
  - Latency: Q/out_valid are visible in the cycle after the edge that sampled the last bit.
- sync in SHIFT (mid-frame or at boundary):
  - The partial word is discarded and bit_cnt restarts at 0 (or 1 if si_en=1 that cycle, the bit becoming bit 0).
  - Q and out_valid are unaffected.
  - A sync coinciding with what would be the last bit counts as a restart, not a completion.
- Once in SHIFT, the block stays there (continuous back-to-back framing) until clear.
- Output handshake:
  - A transfer occurs when out_valid=1 and out_ready=1.
  - Transfer with no completion in that cycle: out_valid <= 0.
  - Transfer and completion in the same cycle: Q gets the new word, out_valid stays 1, no overrun.
  - Completion while out_valid=1 and out_ready=0: Q is overwritten with the new word, out_valid stays 1, overrun <= 1.
  - overrun clears only on clear.
- Q holds its last value after it is consumed; it never returns to 0 except on clear.
- bit_cnt is zero-extended to 4 bits.

Test Plan:
1. clear, REQ_SYNC=1; drive si_en=1 with si=1 for 10 cycles, no sync -> bit_cnt=0, out_valid=0, Q=0x00 throughout.
2. MSB_FIRST=1, out_ready=1; sync with first bit, stream 0xA5 MSB-first on consecutive cycles -> Q=0xA5 in the cycle after the 8th bit edge; out_valid high exactly 1 cycle; bit_cnt sequence 1..7,0.
3. MSB_FIRST=0; stream bit sequence 0,0,0,0,1,1,1,1, with si_en gaps of 2 cycles between bits -> Q=0xF0; bit_cnt advances only on si_en cycles.
4. Send 5 bits, then assert sync with si_en=1, then 7 more bits forming 0x5A -> partial discarded; Q=0x5A after the 8th bit counted from sync.
5. out_ready=0; send 0x11 then 0x22 -> out_valid stays 1, Q=0x22, overrun=1. Then out_ready=1 for 1 cycle -> out_valid=0, Q=0x22, overrun stays 1 until clear.
6. Assert clear at the edge after bit 4 of a frame, with sync and si_en also high -> next cycle: Q=0, out_valid=0, bit_cnt=0, overrun=0, state IDLE.
